// File: rtl/mem_responder_pkg.sv
// Shared types and byte-lane helpers for mem_responder (big-endian lane order).
package mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        DATA,
        RESP
    } state_e;

    // Size code 2'b11 falls through to the word cases below.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_HALF: r = off[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
            SZ_BYTE: begin
                case (off)
                    2'd0:    r = {24'h0, word[31:24]};
                    2'd1:    r = {24'h0, word[23:16]};
                    2'd2:    r = {24'h0, word[15:8]};
                    default: r = {24'h0, word[7:0]};
                endcase
            end
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = data;
        case (size)
            SZ_HALF: r = off[1] ? {word[31:16], data[15:0]} : {data[15:0], word[15:0]};
            SZ_BYTE: begin
                case (off)
                    2'd0:    r = {data[7:0], word[23:0]};
                    2'd1:    r = {word[31:24], data[7:0], word[15:0]};
                    2'd2:    r = {word[31:16], data[7:0], word[7:0]};
                    default: r = {word[31:8], data[7:0]};
                endcase
            end
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word-wide storage: one write port and a registered read with one cycle of latency; never reset.
module mem_responder_array #(
    parameter int AW = 6
) (
    input  logic          Clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge Clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with wait states and read-modify-write sub-word stores.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned word/half accesses via RespErr.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWr,
    input  logic [1:0]  ReqSize,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqData,
    output logic        RespValid,
    output logic [31:0] RespData,
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    output logic        RespErr,
`endif
    output logic        Busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               req_wr_q;
    logic [1:0]         req_size_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic [31:0]        req_data_q;
    logic               req_word;
    logic               arr_we, arr_re;
    logic [31:0]        arr_wdata, arr_rdata;
    logic               unused_addr;

    assign unused_addr = ^ReqAddr[31:ADDR_W];
    assign req_word    = !((req_size_q == SZ_HALF) || (req_size_q == SZ_BYTE));

    always_ff @(posedge Clk) begin
        if (ReqValid && (state_q == IDLE)) begin
            req_wr_q   <= ReqWr;
            req_size_q <= ReqSize;
            req_addr_q <= ReqAddr[ADDR_W-1:0];
            req_data_q <= ReqData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        arr_we      = 1'b0;
        arr_re      = 1'b0;
        arr_wdata   = req_data_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    cnt_d   = WAIT_INIT;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                    if ((!((ReqSize == SZ_HALF) || (ReqSize == SZ_BYTE)) && (ReqAddr[1:0] != 2'b00)) ||
                        ((ReqSize == SZ_HALF) && ReqAddr[0])) begin
                        state_d     = RESP;
                        cnt_d       = cnt_q;
                        resp_data_d = '0;
                    end
`endif
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Word stores skip the read; everything else needs the old word first.
                if (req_wr_q && req_word) begin
                    arr_we      = 1'b1;
                    resp_data_d = '0;
                    state_d     = RESP;
                end else begin
                    arr_re  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (req_wr_q) begin
                    arr_we      = 1'b1;
                    arr_wdata   = lane_merge(arr_rdata, req_data_q, req_size_q, req_addr_q[1:0]);
                    resp_data_d = '0;
                end else begin
                    resp_data_d = lane_extract(arr_rdata, req_size_q, req_addr_q[1:0]);
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic resp_err_q, resp_err_d;

    // Only the misalignment path jumps straight from IDLE into RESP.
    always_comb begin
        resp_err_d = resp_err_q;
        if ((state_d == RESP) && (state_q != RESP)) begin
            resp_err_d = (state_q == IDLE);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end

    assign RespErr = resp_err_q;
`endif

    mem_responder_array #(
        .AW(ADDR_W - 2)
    ) u_array (
        .Clk    (Clk),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .addr_i (req_addr_q[ADDR_W-1:2]),
        .wdata_i(arr_wdata),
        .rdata_o(arr_rdata)
    );

    assign ReqReady  = (state_q == IDLE);
    assign Busy      = (state_q != IDLE);
    assign RespValid = (state_q == RESP);
    assign RespData  = resp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array reference model.
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int WC     = 1;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWr = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic [31:0] ReqAddr = '0;
    logic [31:0] ReqData = '0;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespErr;
    logic        Busy;

    always #5 Clk = ~Clk;

    mem_responder #(
        .ADDR_W(ADDR_W),
        .WAIT_CYCLES(WC)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqWr    (ReqWr),
        .ReqSize  (ReqSize),
        .ReqAddr  (ReqAddr),
        .ReqData  (ReqData),
        .RespValid(RespValid),
        .RespData (RespData),
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        .RespErr  (RespErr),
`endif
        .Busy     (Busy)
    );

`ifndef MEM_RESPONDER_ALIGN_CHECK_EN
    assign RespErr = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mon_en  = 0;
    bit          pending = 0;
    int          c_acc   = 0;
    int          exp_cyc = 0;
    int          last_resp_cyc = -1;
    logic [31:0] exp_data = '0;
    bit          exp_err  = 0;
    logic [7:0]  mb [0:255];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit mdl_is_word(input logic [1:0] sz);
        return !(sz == 2'b01 || sz == 2'b10);
    endfunction

    function automatic bit mdl_misaligned(input logic [1:0] sz, input logic [1:0] a);
        bit m;
        m = (mdl_is_word(sz) && a != 2'b00) || (sz == 2'b01 && a[0]);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        return m;
`else
        return m & 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input int a);
        int w, h;
        w = a & ~3;
        h = w + (a & 2);
        if (sz == 2'b01) return {16'h0, mb[h], mb[h+1]};
        if (sz == 2'b10) return {24'h0, mb[a]};
        return {mb[w], mb[w+1], mb[w+2], mb[w+3]};
    endfunction

    task automatic mdl_store(input logic [1:0] sz, input int a, input logic [31:0] d);
        int w, h;
        w = a & ~3;
        h = w + (a & 2);
        if (sz == 2'b01) begin
            mb[h] = d[15:8]; mb[h+1] = d[7:0];
        end else if (sz == 2'b10) begin
            mb[a] = d[7:0];
        end else begin
            mb[w] = d[31:24]; mb[w+1] = d[23:16]; mb[w+2] = d[15:8]; mb[w+3] = d[7:0];
        end
    endtask

    // Compare process: every cycle once enabled.
    always @(negedge Clk) begin
        if (mon_en) begin
            bit exp_v, busy_e;
            exp_v  = pending && (cyc == exp_cyc);
            busy_e = pending && (cyc > c_acc) && (cyc <= exp_cyc);
            check("resp_valid", {31'b0, RespValid}, {31'b0, exp_v});
            check("req_ready", {31'b0, ReqReady}, {31'b0, !busy_e});
            check("busy", {31'b0, Busy}, {31'b0, busy_e});
            if (RespValid) last_resp_cyc = cyc;
            if (exp_v && RespValid) begin
                check("resp_data", RespData, exp_data);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                check("resp_err", {31'b0, RespErr}, {31'b0, exp_err});
`endif
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge following the response.
    task automatic do_req(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold,
                          output logic [31:0] rdata, output int lat);
        int a, elat;
        a = int'(addr[ADDR_W-1:0]);
        ReqValid = 1'b1; ReqWr = wr; ReqSize = sz; ReqAddr = addr; ReqData = data;
        c_acc = cyc;
        last_resp_cyc = -1;
        if (mdl_misaligned(sz, addr[1:0])) begin
            elat = 1; exp_data = '0; exp_err = 1;
        end else begin
            exp_err = 0;
            if (wr) begin
                exp_data = '0;
                elat = mdl_is_word(sz) ? WC + 2 : WC + 3;
                mdl_store(sz, a, data);
            end else begin
                exp_data = mdl_load(sz, a);
                elat = WC + 3;
            end
        end
        exp_cyc = c_acc + elat;
        pending = 1;
        repeat (elat + 1) begin
            @(posedge Clk); #1;
            if (hold) begin
                ReqAddr = $urandom; ReqData = $urandom;
                ReqWr = 1'($urandom); ReqSize = 2'($urandom);
            end else begin
                ReqValid = 1'b0;
            end
        end
        ReqValid = 1'b0;
        rdata = RespData;
        lat = (last_resp_cyc < 0) ? -1 : last_resp_cyc - c_acc;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;

        repeat (2) @(negedge Clk);
        check("rst_ready", {31'b0, ReqReady}, 32'd1);
        check("rst_valid", {31'b0, RespValid}, 32'd0);
        check("rst_data", RespData, 32'h0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_err", {31'b0, RespErr}, 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        mon_en = 1;

        for (int i = 0; i < 64; i++) do_req(1'b1, 2'b00, 32'(i * 4), $urandom, 1'b0, rd, lat);

        do_req(1'b1, 2'b00, 32'h10, 32'h11223344, 1'b0, rd, lat);
        check("wst_lat", 32'(lat), 32'd3);
        check("wst_data", rd, 32'h0);
        do_req(1'b0, 2'b00, 32'h10, 32'h0, 1'b0, rd, lat);
        check("wld_lat", 32'(lat), 32'd4);
        check("wld_data", rd, 32'h11223344);
        do_req(1'b0, 2'b00, 32'h110, 32'h0, 1'b0, rd, lat);
        check("wrap_data", rd, 32'h11223344);

        do_req(1'b1, 2'b00, 32'h20, 32'hAABBCCDD, 1'b0, rd, lat);
        do_req(1'b1, 2'b10, 32'h21, 32'h000000EE, 1'b0, rd, lat);
        check("bst_lat", 32'(lat), 32'd4);
        do_req(1'b0, 2'b00, 32'h20, 32'h0, 1'b0, rd, lat);
        check("bst_word", rd, 32'hAAEECCDD);
        do_req(1'b0, 2'b10, 32'h21, 32'h0, 1'b0, rd, lat);
        check("bld_data", rd, 32'h000000EE);

        do_req(1'b1, 2'b00, 32'h20, 32'hAABBCCDD, 1'b0, rd, lat);
        do_req(1'b1, 2'b01, 32'h22, 32'h0000BEEF, 1'b0, rd, lat);
        do_req(1'b0, 2'b01, 32'h22, 32'h0, 1'b0, rd, lat);
        check("hld_data", rd, 32'h0000BEEF);
        do_req(1'b0, 2'b00, 32'h20, 32'h0, 1'b0, rd, lat);
        check("hst_word", rd, 32'hAABBBEEF);

        do_req(1'b0, 2'b00, 32'h10, 32'h0, 1'b1, rd, lat);
        check("hold_lat", 32'(lat), 32'd4);
        check("hold_data", rd, 32'h11223344);

        do_req(1'b1, 2'b00, 32'h30, 32'h0BADF00D, 1'b0, rd, lat);
        do_req(1'b0, 2'b00, 32'h30, 32'h0, 1'b0, rd, lat);
        mon_en = 0;
        ReqValid = 1'b1; ReqWr = 1'b1; ReqSize = 2'b00; ReqAddr = 32'h30; ReqData = 32'hDEADBEEF;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        check("abort_busy", {31'b0, Busy}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("abort_ready", {31'b0, ReqReady}, 32'd1);
        check("abort_busy0", {31'b0, Busy}, 32'd0);
        check("abort_valid", {31'b0, RespValid}, 32'd0);
        check("abort_data", RespData, 32'h0);
        repeat (3) begin
            @(negedge Clk);
            check("abort_novalid", {31'b0, RespValid}, 32'd0);
        end
        #2 Reset = 1'b0;
        @(posedge Clk); #1;
        pending = 0;
        mon_en = 1;
        do_req(1'b0, 2'b00, 32'h30, 32'h0, 1'b0, rd, lat);
        check("abort_old", rd, 32'h0BADF00D);

        do_req(1'b0, 2'b00, 32'h13, 32'h0, 1'b0, rd, lat);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_data", rd, 32'h0);
        check("mis_err", {31'b0, RespErr}, 32'd1);
        do_req(1'b1, 2'b01, 32'h11, 32'hFFFFFFFF, 1'b0, rd, lat);
        do_req(1'b0, 2'b00, 32'h10, 32'h0, 1'b0, rd, lat);
        check("mis_nowrite", rd, 32'h11223344);
`else
        check("mis_lat", 32'(lat), 32'd4);
        check("mis_data", rd, 32'h11223344);
`endif

        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom), 2'($urandom), $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), rd, lat);
        end

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle MIPS datapath. It accepts word, halfword and byte requests from the CPU over a valid/ready handshake and applies a configurable number of wait states. Sub-word stores are done as read-modify-write, so neighbouring bytes are preserved. Sub-word loads return data right-aligned and zero-extended, which matches the CPU's MDR-input and store-data selector encodings. The block owns a word-wide storage array and replaces direct connection of the CPU to a fixed-latency memory.

## Interface
- ADDR_W, default 8: byte-address bits used; storage is 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, default 1: wait states per access; legal range 0..15.

- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  block can accept a request; high only in IDLE.
- ReqWr  input  1  1 = store, 0 = load.
- ReqSize  input  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- ReqAddr  input  32  byte address; bits above ADDR_W-1 are ignored, so addresses wrap.
- ReqData  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- RespValid  output  1  one-cycle completion pulse.
- RespData  output  32  load result; 0 for stores.
- RespErr  output  1  misaligned-access flag; exists only with the macro.
- Busy  output  1  high in every state except IDLE.

## Operation
- Byte lanes are big-endian: byte offset 0 is in [31:24], offset 3 in [7:0]; half offset 0 is in [31:16].
- A request is accepted in a cycle where ReqValid and ReqReady are both high. ReqWr, ReqSize, ReqAddr and ReqData are latched on that edge; later changes are ignored.
- ReqValid outside IDLE is ignored; requests are not queued.
- There is no backpressure on responses. RespValid is high for exactly one cycle, and RespData/RespErr are valid only in that cycle. Outside it they hold their last values.
- State machine:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: count down WAIT_CYCLES cycles, then go to ACCESS.
  - ACCESS: a word store writes the array and goes to RESP. A load or sub-word store issues a synchronous array read and goes to DATA.
  - DATA: a load latches the formatted result. A sub-word store merges its byte/half into the read word and writes the array. Both then go to RESP.
  - RESP: RespValid=1, then go to IDLE.
- Load formatting:
  - word: the full word at addr&~3.
  - half: the selected half, zero-extended.
  - byte: the selected byte, zero-extended.
- Every write is committed before its RespValid. A load accepted afterwards sees the new data.
- Reset mid-transaction aborts it with no response. A store not yet committed is lost. Array contents are never reset.
- Reset values: state IDLE, ReqReady=1, RespValid=0, RespData=0, RespErr=0, Busy=0, wait counter 0.

## Timing
- The accept cycle is cycle 0.
- Load or sub-word store: RespValid in cycle WAIT_CYCLES+3.
- Word store: RespValid in cycle WAIT_CYCLES+2.
- ReqReady rises in the cycle after RespValid, so back-to-back issue is possible one cycle after each response.
- Misaligned error response (macro on): RespValid in cycle 1.

## Configuration
- Macro MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - A word access with addr[1:0]≠0, or a half access with addr[0]=1, goes IDLE→RESP directly.
  - That response has RespErr=1 and RespData=0; there is no array access and no write.
- Undefined:
  - The RespErr port is absent.
  - Word accesses ignore addr[1:0]; half accesses ignore addr[0] and use addr[1].

## Structure
- Package mem_responder_pkg holds:
  - the size enum (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10);
  - the state enum (IDLE, WAIT, ACCESS, DATA, RESP);
  - lane-extract and lane-merge functions.
- One sub-module, mem_responder_array: a word-wide array with one write port and a registered read, 1-cycle latency, no reset.

## Test plan
- Reset, then a word store of 0x11223344 at 0x10, then a word load at 0x10 (WAIT_CYCLES=1) → store RespValid in cycle 3, load RespValid in cycle 4 with RespData=0x11223344.
- Preload 0xAABBCCDD at 0x20, byte store of ReqData=0x000000EE at 0x21, word load at 0x20 → RespData=0xAAEECCDD; byte load at 0x21 → 0x000000EE.
- Half store of 0x0000BEEF at 0x22 over 0xAABBCCDD, then half load at 0x22 → 0x0000BEEF; word load → 0xAABBBEEF.
- ReqValid held high during a transaction with changing ReqAddr → exactly one response, using the address latched at accept; ReqReady=0 until the cycle after RespValid.
- Reset asserted asynchronously in WAIT of a word store of 0xDEADBEEF to 0x30 → no RespValid; outputs return to reset values at once; a later load of 0x30 returns the old contents.
- Macro on: word load at 0x13 → RespValid in cycle 1 with RespErr=1 and RespData=0, no array write. Macro off: the same request returns the word at 0x10.
